// File: rtl/pc_seq_pkg.sv
// Shared encodings for the multi-cycle PC sequencer.
// Op classes come from the decoder; stages are exported on the stage port.
package pc_seq_pkg;

    localparam int PC_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JUMP   = 3'd4,
        OP_CALL   = 3'd5,
        OP_RET    = 3'd6,
        OP_HALT   = 3'd7
    } op_class_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } stage_e;

endpackage

// File: rtl/return_addr_stack.sv
// Small LIFO of return addresses for CALL/RET.
// Push when full and pop when empty leave the pointer untouched.
module return_addr_stack
    import pc_seq_pkg::*;
#(
    parameter int WIDTH     = PC_WIDTH,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(RAS_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [AW-1:0]    top_idx;
    logic [PW-1:0]    ptr_dec;

    assign ptr_dec = ptr - PW'(1);
    assign top_idx = ptr_dec[AW-1:0];
    assign full    = (ptr == PW'(RAS_DEPTH));
    assign empty   = (ptr == '0);
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + PW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr_dec;
        end
    end

    // Entries need no reset: the pointer alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Multi-cycle instruction sequencer producing the PC register in/EN pair.
// pc_en pulses for one cycle in the last stage of every instruction.
module pc_next_unit
    import pc_seq_pkg::*;
#(
    parameter int WIDTH     = PC_WIDTH,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             instr_valid,
    input  logic [2:0]       op_class,
    input  logic [WIDTH-1:0] imm,
    input  logic             br_taken,
    output logic [WIDTH-1:0] pc_next,
    output logic             pc_en,
    output logic [2:0]       stage,
    output logic             halted,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    stage_e           state, state_n;
    op_class_e        op_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] pc_inc;
    logic             push, pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_full, ras_empty;
    logic             in_exec;

    assign pc_inc  = pc + WIDTH'(1);
    assign in_exec = (state == ST_EXEC);
    assign stage   = state;
    assign halted  = (state == ST_HALTED);

    return_addr_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_FETCH;
            op_q          <= OP_ALU;
            imm_q         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            state <= state_n;
            if (state == ST_DECODE) begin
                op_q  <= op_class_e'(op_class);
                imm_q <= imm;
            end
            if (in_exec && op_q == OP_CALL && ras_full) begin
                ras_overflow <= 1'b1;
            end
            if (in_exec && op_q == OP_RET && ras_empty) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        pc_en   = 1'b0;
        pc_next = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state)
            ST_FETCH: begin
                if (instr_valid) state_n = ST_DECODE;
            end
            ST_DECODE: state_n = ST_EXEC;
            ST_EXEC: begin
                unique case (op_q)
                    OP_ALU:            state_n = ST_WB;
                    OP_LOAD, OP_STORE: state_n = ST_MEM;
                    OP_HALT:           state_n = ST_HALTED;
                    OP_BRANCH: begin
                        state_n = ST_FETCH;
                        pc_en   = 1'b1;
                        if (br_taken) pc_next = pc + imm_q;
                    end
                    OP_JUMP: begin
                        state_n = ST_FETCH;
                        pc_en   = 1'b1;
                        pc_next = imm_q;
                    end
                    OP_CALL: begin
                        state_n = ST_FETCH;
                        pc_en   = 1'b1;
                        pc_next = imm_q;
                        push    = !ras_full;
                    end
                    OP_RET: begin
                        state_n = ST_FETCH;
                        pc_en   = 1'b1;
                        pop     = !ras_empty;
                        if (!ras_empty) pc_next = ras_top;
                    end
                endcase
            end
            ST_MEM: begin
                if (op_q == OP_STORE) begin
                    state_n = ST_FETCH;
                    pc_en   = 1'b1;
                end else begin
                    state_n = ST_WB;
                end
            end
            ST_WB: begin
                state_n = ST_FETCH;
                pc_en   = 1'b1;
            end
            ST_HALTED: state_n = ST_HALTED;
            default:   state_n = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Scenario bench for pc_next_unit: expected PC updates are queued per
// instruction and popped when the sequencer raises pc_en.
module tb_pc_next_unit;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc = 16'h1234;
    logic        instr_valid = 1'b0;
    logic [2:0]  op_class = 3'd0;
    logic [15:0] imm = 16'h0;
    logic        br_taken = 1'b0;
    logic [15:0] pc_next;
    logic        pc_en;
    logic [2:0]  stage;
    logic        halted;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    pc_next_unit #(.WIDTH(16), .RAS_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .instr_valid   (instr_valid),
        .op_class      (op_class),
        .imm           (imm),
        .br_taken      (br_taken),
        .pc_next       (pc_next),
        .pc_en         (pc_en),
        .stage         (stage),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs one instruction from FETCH; returns the pc_next seen with pc_en,
    // the cycle count, the stage trace and pc_en one cycle later.
    task automatic exec_instr(
        input  logic [2:0]  op,
        input  logic [15:0] p,
        input  logic [15:0] im,
        input  logic        tk,
        input  int          waits,
        input  int          limit,
        output logic [15:0] got,
        output int          lat,
        output logic [23:0] trace,
        output logic        seen,
        output logic        en_after
    );
        pc = p;
        op_class = op;
        imm = im;
        br_taken = tk;
        instr_valid = (waits == 0);
        lat = 0;
        seen = 1'b0;
        got = '0;
        trace = '0;
        en_after = 1'b0;
        while (!seen && lat < limit) begin
            @(negedge clk);
            lat++;
            if (lat <= 8) trace[3*(lat-1)+:3] = stage;
            if (pc_en) begin
                seen = 1'b1;
                got = pc_next;
            end
            if (lat == waits + 1) instr_valid = 1'b1;
            if (stage >= 3'd2) begin
                op_class = ~op;
                imm = ~im;
            end
        end
        if (seen) begin
            @(posedge clk);
            #1 en_after = pc_en;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc = 16'h1234;
        #3;
        checks++;
        if (stage !== 3'd0) begin
            errors++; $display("FAIL reset_stage got %0d exp 0", stage);
        end
        checks++;
        if (pc_en !== 1'b0) begin
            errors++; $display("FAIL reset_pc_en got %b exp 0", pc_en);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++; $display("FAIL reset_halted got %b exp 0", halted);
        end
        checks++;
        if ({ras_overflow, ras_underflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got %b%b exp 00",
                     ras_overflow, ras_underflow);
        end
        checks++;
        if (pc_next !== 16'h1235) begin
            errors++; $display("FAIL reset_pc_next got %h exp 1235", pc_next);
        end
        do_reset();
    endtask

    task automatic test_alu();
        logic [15:0] got, e;
        int lat;
        logic [23:0] tr;
        logic seen, ea;
        exp_q.push_back(16'h0011);
        exec_instr(3'(OP_ALU), 16'h0010, 16'h0005, 1'b1, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e) begin
            errors++; $display("FAIL alu_pc_next got %h exp %h", got, e);
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL alu_latency got %0d exp 4", lat);
        end
        checks++;
        if (tr[11:0] !== 12'b100_010_001_000) begin
            errors++; $display("FAIL alu_trace got %b exp 100010001000", tr[11:0]);
        end
        checks++;
        if (ea !== 1'b0) begin
            errors++; $display("FAIL alu_pulse got %b exp 0", ea);
        end
    endtask

    task automatic test_branch();
        logic [15:0] got, e;
        int lat;
        logic [23:0] tr;
        logic seen, ea;
        exp_q.push_back(16'h001C);
        exec_instr(3'(OP_BRANCH), 16'h0020, 16'hFFFC, 1'b1, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e) begin
            errors++; $display("FAIL br_taken_pc got %h exp %h", got, e);
        end
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL br_latency got %0d exp 3", lat);
        end
        checks++;
        if (ea !== 1'b0) begin
            errors++; $display("FAIL br_pulse got %b exp 0", ea);
        end
        exp_q.push_back(16'h0021);
        exec_instr(3'(OP_BRANCH), 16'h0020, 16'hFFFC, 1'b0, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e) begin
            errors++; $display("FAIL br_not_taken_pc got %h exp %h", got, e);
        end
    endtask

    task automatic test_load_wait();
        logic [15:0] got, e;
        int lat;
        logic [23:0] tr;
        logic seen, ea;
        do_reset();
        exp_q.push_back(16'h0101);
        exec_instr(3'(OP_LOAD), 16'h0100, 16'h0033, 1'b0, 3, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e) begin
            errors++; $display("FAIL load_pc_next got %h exp %h", got, e);
        end
        checks++;
        if (lat !== 8) begin
            errors++; $display("FAIL load_latency got %0d exp 8", lat);
        end
    endtask

    task automatic test_store_wrap();
        logic [15:0] got, e;
        int lat;
        logic [23:0] tr;
        logic seen, ea;
        exp_q.push_back(16'h0ABD);
        exec_instr(3'(OP_STORE), 16'h0ABC, 16'h0000, 1'b0, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e || lat !== 4) begin
            errors++;
            $display("FAIL store got %h lat %0d exp %h lat 4", got, lat, e);
        end
        exp_q.push_back(16'h0000);
        exec_instr(3'(OP_ALU), 16'hFFFF, 16'h1111, 1'b1, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e) begin
            errors++; $display("FAIL alu_wrap got %h exp %h", got, e);
        end
    endtask

    task automatic test_call_ret();
        logic [15:0] got, e;
        int lat;
        logic [23:0] tr;
        logic seen, ea;
        do_reset();
        exp_q.push_back(16'h0200);
        exec_instr(3'(OP_CALL), 16'h0040, 16'h0200, 1'b0, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e || lat !== 3) begin
            errors++;
            $display("FAIL call got %h lat %0d exp %h lat 3", got, lat, e);
        end
        exp_q.push_back(16'h0041);
        exec_instr(3'(OP_RET), 16'h0200, 16'h0000, 1'b0, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e) begin
            errors++; $display("FAIL ret got %h exp %h", got, e);
        end
        checks++;
        if ({ras_overflow, ras_underflow} !== 2'b00) begin
            errors++;
            $display("FAIL call_ret_flags got %b%b exp 00",
                     ras_overflow, ras_underflow);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] got, e, p;
        int lat;
        logic [23:0] tr;
        logic seen, ea;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            p = 16'h0100 + 16'(i * 16);
            exp_q.push_back(p + 16'h0010);
            exec_instr(3'(OP_CALL), p, p + 16'h0010, 1'b0, 0, 20,
                       got, lat, tr, seen, ea);
            e = exp_q.pop_front();
            checks++;
            if (!seen || got !== e) begin
                errors++; $display("FAIL nest_call%0d got %h exp %h", i, got, e);
            end
            if (i == 3) begin
                checks++;
                if (ras_overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_early got 1 exp 0");
                end
            end
        end
        checks++;
        if (ras_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set got %b exp 1", ras_overflow);
        end
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back(16'h0101 + 16'(i * 16));
        end
        exp_q.push_back(16'h0901);
        for (int i = 0; i < 5; i++) begin
            exec_instr(3'(OP_RET), 16'h0900, 16'h0000, 1'b0, 0, 20,
                       got, lat, tr, seen, ea);
            e = exp_q.pop_front();
            checks++;
            if (!seen || got !== e) begin
                errors++; $display("FAIL nest_ret%0d got %h exp %h", i, got, e);
            end
            if (i == 3) begin
                checks++;
                if (ras_underflow !== 1'b0) begin
                    errors++; $display("FAIL udf_early got 1 exp 0");
                end
            end
        end
        checks++;
        if (ras_underflow !== 1'b1) begin
            errors++; $display("FAIL udf_after_drain got %b exp 1", ras_underflow);
        end
    endtask

    task automatic test_underflow();
        logic [15:0] got, e;
        int lat;
        logic [23:0] tr;
        logic seen, ea;
        do_reset();
        exp_q.push_back(16'h0301);
        exec_instr(3'(OP_RET), 16'h0300, 16'h0777, 1'b0, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e) begin
            errors++; $display("FAIL udf_pc got %h exp %h", got, e);
        end
        checks++;
        if ({ras_overflow, ras_underflow} !== 2'b01) begin
            errors++;
            $display("FAIL udf_flags got %b%b exp 01",
                     ras_overflow, ras_underflow);
        end
    endtask

    task automatic test_halt();
        logic [15:0] got;
        int lat, en_cnt;
        logic [23:0] tr;
        logic seen, ea;
        do_reset();
        exec_instr(3'(OP_HALT), 16'h0400, 16'h0000, 1'b0, 0, 6,
                   got, lat, tr, seen, ea);
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL halt_no_en got %b exp 0", seen);
        end
        checks++;
        if (stage !== 3'd5 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_state got %0d/%b exp 5/1", stage, halted);
        end
        en_cnt = 0;
        instr_valid = 1'b1;
        op_class = 3'(OP_JUMP);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pc_en) en_cnt++;
        end
        checks++;
        if (en_cnt !== 0 || stage !== 3'd5) begin
            errors++;
            $display("FAIL halt_hold got en %0d stage %0d exp 0/5", en_cnt, stage);
        end
        checks++;
        if (pc_next !== 16'h0401) begin
            errors++; $display("FAIL halt_pc_next got %h exp 0401", pc_next);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got, e;
        int lat, n;
        logic [23:0] tr;
        logic seen, ea;
        do_reset();
        exp_q.push_back(16'h0600);
        exec_instr(3'(OP_CALL), 16'h0500, 16'h0600, 1'b0, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e) begin
            errors++; $display("FAIL pre_call got %h exp %h", got, e);
        end
        pc = 16'h0050;
        op_class = 3'(OP_JUMP);
        imm = 16'h0ABC;
        instr_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stage !== 3'd2 && n < 10);
        checks++;
        if (pc_en !== 1'b1 || pc_next !== 16'h0ABC) begin
            errors++;
            $display("FAIL jump_exec got %b/%h exp 1/0abc", pc_en, pc_next);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (pc_en !== 1'b0 || stage !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset got en %b stage %0d exp 0/0", pc_en, stage);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back(16'h0778);
        exec_instr(3'(OP_RET), 16'h0777, 16'h0000, 1'b0, 0, 20,
                   got, lat, tr, seen, ea);
        e = exp_q.pop_front();
        checks++;
        if (!seen || got !== e || ras_underflow !== 1'b1) begin
            errors++;
            $display("FAIL stack_flushed got %h udf %b exp %h udf 1",
                     got, ras_underflow, e);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load_wait();
        test_store_wrap();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
